// File: rtl/sensor_poll_ctrl.sv
// rtl/sensor_poll_ctrl.sv - multi-sensor UART poller with framed response check, timeout and retry (optional SENSOR_STATS_EN)
module sensor_poll_ctrl #(
    parameter int          N_SENSORS   = 4,
    parameter int          DATA_BYTES  = 1,
    parameter int          TIMEOUT_CYC = 50000,
    parameter int          MAX_RETRY   = 2,
    parameter logic [7:0]  CHK_KEY     = 8'h37
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [31:0]             dataa,
    output logic [7:0]              SendUart,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [7:0]              ReadUart,
    input  logic                    rx_valid,
    output logic [7:0]              result,
    output logic [8*DATA_BYTES-1:0] rdata,
    output logic                    done,
    output logic                    busy
);

    localparam int DW  = 8 * DATA_BYTES;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int RCW = $clog2(MAX_RETRY + 2);
    localparam int BCW = 3;

    localparam logic [TW-1:0]  TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [RCW-1:0] RETRY_LAST = RCW'(MAX_RETRY);
    localparam logic [BCW-1:0] BYTE_LAST  = BCW'(DATA_BYTES - 1);

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'h0C;
    localparam logic [7:0] ST_ID      = 8'h0D;
    localparam logic [7:0] ST_CHK     = 8'h0E;
    localparam logic [7:0] ST_BADIDX  = 8'h0F;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ID,
        RECV_DATA,
        RECV_CHK,
        CHECK,
        DONE
    } state_t;

    state_t          state;
    logic [7:0]      idx;
    logic [RCW-1:0]  retry_cnt;
    logic [TW-1:0]   to_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic [DW-1:0]   hold;
    logic [7:0]      acc;
    logic [7:0]      chk;
    logic            id_err;
    logic            to_err;
    logic            direct;
    logic [7:0]      direct_code;

    logic [7:0]      frame_code;
    logic            retry_exhausted;
    logic            idx_bad;
    logic            to_expire;
    logic [DW+7:0]   shifted;
    logic [DW-1:0]   stat_value;

    wire unused_dataa = ^dataa[31:8];

    // Frame verdict, evaluated while in CHECK: timeout, then ID, then checksum
    always_comb begin
        frame_code = ST_OK;
        if (to_err)
            frame_code = ST_TIMEOUT;
        else if (id_err)
            frame_code = ST_ID;
        else if (chk != (acc ^ CHK_KEY))
            frame_code = ST_CHK;
    end

    assign retry_exhausted = (retry_cnt == RETRY_LAST);
    assign idx_bad         = (32'(dataa[7:0]) >= 32'(N_SENSORS));
    assign to_expire       = (to_cnt == TO_LAST);
    assign shifted         = {hold, ReadUart};

`ifdef SENSOR_STATS_EN
    localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

    logic [7:0] fail_cnt [2**IW];
    logic       stat_inc;

    // A transaction's final failure bumps its sensor counter once; retries and bad indices do not
    assign stat_inc   = (state == CHECK) && !direct && (frame_code != ST_OK) && retry_exhausted;
    assign stat_value = DW'(fail_cnt[dataa[IW-1:0]]);

    // Saturating per-sensor failure counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2**IW; i++)
                fail_cnt[i] <= 8'h00;
        end else if (stat_inc && (fail_cnt[idx[IW-1:0]] != 8'hFF)) begin
            fail_cnt[idx[IW-1:0]] <= fail_cnt[idx[IW-1:0]] + 8'h01;
        end
    end
`else
    assign stat_value = '0;
`endif

    // Transaction sequencer: request, framed receive, verdict, retry, completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            SendUart    <= 8'h00;
            tx_valid    <= 1'b0;
            result      <= 8'h00;
            rdata       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            idx         <= 8'h00;
            retry_cnt   <= '0;
            to_cnt      <= '0;
            byte_cnt    <= '0;
            hold        <= '0;
            acc         <= 8'h00;
            chk         <= 8'h00;
            id_err      <= 1'b0;
            to_err      <= 1'b0;
            direct      <= 1'b0;
            direct_code <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        idx       <= dataa[7:0];
                        busy      <= 1'b1;
                        retry_cnt <= '0;
                        if (idx_bad) begin
                            direct      <= 1'b1;
                            direct_code <= ST_BADIDX;
                            state       <= CHECK;
                        end
`ifdef SENSOR_STATS_EN
                        else if (dataa[8]) begin
                            direct      <= 1'b1;
                            direct_code <= ST_OK;
                            hold        <= stat_value;
                            state       <= CHECK;
                        end
`endif
                        else begin
                            direct   <= 1'b0;
                            tx_valid <= 1'b1;
                            SendUart <= dataa[7:0];
                            state    <= SEND;
                        end
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        to_cnt   <= '0;
                        byte_cnt <= '0;
                        acc      <= 8'h00;
                        id_err   <= 1'b0;
                        to_err   <= 1'b0;
                        state    <= WAIT_ID;
                    end
                end

                WAIT_ID: begin
                    if (rx_valid) begin
                        acc    <= ReadUart;
                        id_err <= (ReadUart != idx);
                        to_cnt <= '0;
                        state  <= RECV_DATA;
                    end else if (to_expire) begin
                        to_err <= 1'b1;
                        state  <= CHECK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RECV_DATA: begin
                    if (rx_valid) begin
                        hold     <= shifted[DW-1:0];
                        acc      <= acc ^ ReadUart;
                        to_cnt   <= '0;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == BYTE_LAST)
                            state <= RECV_CHK;
                    end else if (to_expire) begin
                        to_err <= 1'b1;
                        state  <= CHECK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RECV_CHK: begin
                    if (rx_valid) begin
                        chk    <= ReadUart;
                        to_cnt <= '0;
                        state  <= CHECK;
                    end else if (to_expire) begin
                        to_err <= 1'b1;
                        state  <= CHECK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    if (direct) begin
                        done   <= 1'b1;
                        result <= direct_code;
                        rdata  <= (direct_code == ST_OK) ? hold : '0;
                        state  <= DONE;
                    end else if (frame_code == ST_OK) begin
                        done   <= 1'b1;
                        result <= ST_OK;
                        rdata  <= hold;
                        state  <= DONE;
                    end else if (!retry_exhausted) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        tx_valid  <= 1'b1;
                        SendUart  <= idx;
                        state     <= SEND;
                    end else begin
                        done   <= 1'b1;
                        result <= frame_code;
                        rdata  <= '0;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// tb/tb_sensor_poll_ctrl.sv - directed self-checking bench for sensor_poll_ctrl
module tb_sensor_poll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] dataa;
    logic [7:0]  SendUart;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  ReadUart;
    logic        rx_valid;
    logic [7:0]  result;
    logic [7:0]  rdata;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sensor_poll_ctrl #(
        .N_SENSORS  (4),
        .DATA_BYTES (1),
        .TIMEOUT_CYC(20),
        .MAX_RETRY  (2),
        .CHK_KEY    (8'h37)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .dataa   (dataa),
        .SendUart(SendUart),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ReadUart(ReadUart),
        .rx_valid(rx_valid),
        .result  (result),
        .rdata   (rdata),
        .done    (done),
        .busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        ReadUart = b;
        tick();
        rx_valid = 1'b0;
        ReadUart = 8'h00;
    endtask

    // Starts a poll and plays the UART side until done or the cycle budget runs out
    task automatic poll(input logic [31:0] d, input bit respond,
                        input logic [7:0] id, input logic [7:0] dat, input logic [7:0] ck,
                        output int reqs, output int cyc, output bit seen, output logic [7:0] last_send);
        enable = 1'b1;
        dataa  = d;
        tick();
        enable = 1'b0;
        cyc = 1; reqs = 0; seen = 1'b0; last_send = 8'hxx;
        while (!seen && cyc < 400) begin
            if (done) begin
                seen = 1'b1;
            end else if (tx_valid && tx_ready) begin
                reqs++;
                last_send = SendUart;
                tick(); cyc++;
                if (respond) begin
                    send_byte(id); send_byte(dat); send_byte(ck);
                    cyc += 3;
                end
            end else begin
                tick(); cyc++;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen, output int txs);
        seen = 1'b0; txs = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (tx_valid) txs++;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; dataa = '0; tx_ready = 1'b1; rx_valid = 1'b0; ReadUart = 8'h00;
        repeat (3) tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata); end
        total++; if (SendUart !== 8'h00) begin bad++; $display("FAIL reset_senduart got=%h want=00", SendUart); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        int reqs, cyc; bit seen; logic [7:0] ls;
        poll(32'd2, 1'b1, 8'h02, 8'h5A, 8'h6F, reqs, cyc, seen, ls);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL good_done got=%b want=1", seen); end
        total++; if (reqs !== 1) begin bad++; $display("FAIL good_reqs got=%0d want=1", reqs); end
        total++; if (ls !== 8'h02) begin bad++; $display("FAIL good_senduart got=%h want=02", ls); end
        total++; if (cyc !== 6) begin bad++; $display("FAIL good_latency got=%0d want=6", cyc); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL good_result got=%h want=00", result); end
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL good_rdata got=%h want=5a", rdata); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_single got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_drop got=%b want=0", busy); end
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL good_rdata_hold got=%h want=5a", rdata); end
    endtask

    task automatic test_bad_checksum();
        int reqs, cyc; bit seen; logic [7:0] ls;
        poll(32'd1, 1'b1, 8'h01, 8'h10, 8'h00, reqs, cyc, seen, ls);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL chk_done got=%b want=1", seen); end
        total++; if (reqs !== 3) begin bad++; $display("FAIL chk_reqs got=%0d want=3", reqs); end
        total++; if (result !== 8'h0E) begin bad++; $display("FAIL chk_result got=%h want=0e", result); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL chk_rdata got=%h want=00", rdata); end
        tick();
    endtask

    task automatic test_id_mismatch();
        int reqs, cyc; bit seen; logic [7:0] ls;
        poll(32'd2, 1'b1, 8'h03, 8'h44, 8'h70, reqs, cyc, seen, ls);
        total++; if (reqs !== 3) begin bad++; $display("FAIL idm_reqs got=%0d want=3", reqs); end
        total++; if (result !== 8'h0D) begin bad++; $display("FAIL idm_result got=%h want=0d", result); end
        total++; if (ls !== 8'h02) begin bad++; $display("FAIL idm_senduart got=%h want=02", ls); end
        tick();
    endtask

    task automatic test_timeout();
        int reqs, cyc; bit seen; logic [7:0] ls;
        poll(32'd3, 1'b0, 8'h00, 8'h00, 8'h00, reqs, cyc, seen, ls);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL to_done got=%b want=1", seen); end
        total++; if (reqs !== 3) begin bad++; $display("FAIL to_reqs got=%0d want=3", reqs); end
        total++; if (cyc !== 67) begin bad++; $display("FAIL to_latency got=%0d want=67", cyc); end
        total++; if (result !== 8'h0C) begin bad++; $display("FAIL to_result got=%h want=0c", result); end
        tick();
    endtask

    task automatic test_expiry_rx();
        bit seen; int txs;
        enable = 1'b1; dataa = 32'd0;
        tick();
        enable = 1'b0;
        tick();
        repeat (19) tick();
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h26);
        wait_done(10, seen, txs);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL exp_done got=%b want=1", seen); end
        total++; if (txs !== 0) begin bad++; $display("FAIL exp_resend got=%0d want=0", txs); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL exp_result got=%h want=00", result); end
        total++; if (rdata !== 8'h11) begin bad++; $display("FAIL exp_rdata got=%h want=11", rdata); end
        tick();
    endtask

    task automatic test_bad_index();
        int reqs, cyc; bit seen; logic [7:0] ls;
        poll(32'd5, 1'b0, 8'h00, 8'h00, 8'h00, reqs, cyc, seen, ls);
        total++; if (reqs !== 0) begin bad++; $display("FAIL bidx_tx got=%0d want=0", reqs); end
        total++; if (cyc !== 2) begin bad++; $display("FAIL bidx_latency got=%0d want=2", cyc); end
        total++; if (result !== 8'h0F) begin bad++; $display("FAIL bidx_result got=%h want=0f", result); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL bidx_rdata got=%h want=00", rdata); end
        tick();
    endtask

    task automatic test_busy_enable();
        bit seen; int txs; bit extra;
        enable = 1'b1; dataa = 32'd1;
        tick();
        enable = 1'b0;
        total++; if (SendUart !== 8'h01) begin bad++; $display("FAIL busy_senduart got=%h want=01", SendUart); end
        tick();
        enable = 1'b1; dataa = 32'd3;
        tick();
        enable = 1'b0;
        send_byte(8'h01); send_byte(8'h77); send_byte(8'h41);
        wait_done(10, seen, txs);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL busy_done got=%b want=1", seen); end
        total++; if (txs !== 0) begin bad++; $display("FAIL busy_resend got=%0d want=0", txs); end
        total++; if (rdata !== 8'h77) begin bad++; $display("FAIL busy_rdata got=%h want=77", rdata); end
        enable = 1'b1; dataa = 32'd3;
        tick();
        enable = 1'b0;
        extra = 1'b0;
        repeat (3) begin
            if (busy || tx_valid) extra = 1'b1;
            tick();
        end
        total++; if (extra !== 1'b0) begin bad++; $display("FAIL busy_enable_ignored got=%b want=0", extra); end
    endtask

    task automatic test_tx_stall();
        bit seen; int txs; bit early;
        tx_ready = 1'b0;
        enable = 1'b1; dataa = 32'd0;
        tick();
        enable = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done || !tx_valid) early = 1'b1;
            if (i % 7 == 3) send_byte(8'h00);
            else tick();
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b want=0", early); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
        tx_ready = 1'b1;
        tick();
        send_byte(8'h00); send_byte(8'h9C); send_byte(8'hAB);
        wait_done(10, seen, txs);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", seen); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL stall_result got=%h want=00", result); end
        total++; if (rdata !== 8'h9C) begin bad++; $display("FAIL stall_rdata got=%h want=9c", rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int reqs, cyc; bit seen; logic [7:0] ls;
        enable = 1'b1; dataa = 32'd5;
        tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1; dataa = 32'd2;
        tick();
        enable = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_send_tx_valid got=%b want=0", tx_valid); end
        tick();
        enable = 1'b1; dataa = 32'd2;
        tick();
        enable = 1'b0;
        tick();
        send_byte(8'h02);
        reset = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_mid_result got=%h want=00", result); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", done); end
        reset = 1'b1;
        tick();
        poll(32'd2, 1'b1, 8'h02, 8'h5A, 8'h6F, reqs, cyc, seen, ls);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_poll_done got=%b want=1", seen); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_poll_result got=%h want=00", result); end
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL rst_poll_rdata got=%h want=5a", rdata); end
        tick();
    endtask

`ifdef SENSOR_STATS_EN
    task automatic test_stats();
        int reqs, cyc; bit seen; logic [7:0] ls;
        poll(32'd1, 1'b1, 8'h01, 8'h10, 8'h00, reqs, cyc, seen, ls);
        tick();
        poll(32'd1, 1'b1, 8'h01, 8'h10, 8'h00, reqs, cyc, seen, ls);
        tick();
        poll(32'h101, 1'b0, 8'h00, 8'h00, 8'h00, reqs, cyc, seen, ls);
        total++; if (reqs !== 0) begin bad++; $display("FAIL stats_tx got=%0d want=0", reqs); end
        total++; if (cyc !== 2) begin bad++; $display("FAIL stats_latency got=%0d want=2", cyc); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL stats_result got=%h want=00", result); end
        total++; if (rdata !== 8'h02) begin bad++; $display("FAIL stats_rdata got=%h want=02", rdata); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_id_mismatch();
        test_timeout();
        test_expiry_rx();
        test_bad_index();
        test_busy_enable();
        test_tx_stall();
        test_reset_mid();
`ifdef SENSOR_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_poll_ctrl.md
Name: sensor_poll_ctrl

Overview:
Parametrised successor to the single-channel UART sensor poller. The block sits between the processor custom-instruction port and a byte-wide UART.
- Start command: enable pulse, sensor index taken from dataa.
- Sends a request byte, then receives a framed response: ID byte, DATA_BYTES data bytes, checksum byte.
- Validates the response, retries on failure and reports a status code plus data.
- Adds over the previous block: N sensors, multi-byte data, a programmable timeout, retries, and a tx/rx handshake.

Parameters:
N_SENSORS, 4, number of addressable sensors (index 0..N_SENSORS-1)
DATA_BYTES, 1, data bytes per response frame (1..4)
TIMEOUT_CYC, 50000, idle clk cycles allowed between response bytes
MAX_RETRY, 2, request re-sends after the first attempt before reporting failure
CHK_KEY, 8'h37, XOR key folded into the checksum

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  start pulse; sampled in IDLE only
dataa  in  32  [7:0] sensor index; [8] stats-read command (optional feature); rest ignored
SendUart  out  8  request byte to UART transmitter
tx_valid  out  1  SendUart valid
tx_ready  in  1  UART transmitter accepts byte
ReadUart  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, ReadUart valid
result  out  8  status code
rdata  out  8*DATA_BYTES  sensor data, first received byte in MSBs
done  out  1  one-cycle completion pulse
busy  out  1  high from start accept until the done cycle

Behaviour:
- Reset (clk edge with reset=0):
  - State goes to IDLE.
  - SendUart, tx_valid, result, rdata, done and busy all go to 0.
  - Retry and timeout counters clear.
  - Applies mid-transaction; tx_valid drops on the same edge.
- Status codes: 8'h00 OK, 8'h0C timeout, 8'h0E checksum error, 8'h0D ID mismatch, 8'h0F bad index.
- IDLE:
  - enable=1 latches the index; busy goes high next cycle.
  - Index >= N_SENSORS: go to DONE with 8'h0F, no UART traffic.
  - Otherwise go to SEND.
- SEND:
  - tx_valid=1, SendUart=index.
  - Hold until tx_valid and tx_ready are both high on a cycle; then go to WAIT_ID with the timeout counter cleared.
  - First tx_valid occurs 1 cycle after enable.
- WAIT_ID:
  - rx_valid captures the ID; go to RECV_DATA.
  - If the ID differs from the index, the failure is flagged but the frame is still consumed.
- RECV_DATA: byte counter 0..DATA_BYTES-1, shifts bytes into a holding register; go to RECV_CHK after the last byte.
- RECV_CHK: rx_valid captures the checksum; go to CHECK.
- CHECK (1 cycle):
  - Expected checksum = ID ^ all data bytes ^ CHK_KEY.
  - Priority: ID mismatch, then checksum error, then OK.
- Timeout:
  - Counter runs in WAIT_ID, RECV_DATA and RECV_CHK, and clears on every rx_valid.
  - Reaching TIMEOUT_CYC-1 with no byte is a timeout failure.
  - rx_valid on the expiry cycle wins; the byte is accepted and there is no timeout.
- Retry: on any UART failure with retry count < MAX_RETRY, increment the count, discard the partial frame and return to SEND. Otherwise go to DONE with the last failure code.
- DONE:
  - done=1 for exactly one cycle; result is updated.
  - rdata is loaded on OK and cleared to 0 on failure.
  - busy drops the cycle after done; return to IDLE.
- Held values: result and rdata hold until the next done.
- Ignored inputs:
  - enable while busy.
  - rx_valid in IDLE, SEND or DONE; such bytes are dropped.
- Minimum transaction with ideal UART: 1 (accept) + 1 (SEND) + DATA_BYTES+2 byte cycles + 1 (CHECK) + 1 (DONE).

Optional Feature:
SENSOR_STATS_EN
- With the macro defined: per-sensor 8-bit failure counters, saturating at 8'hFF, incremented once per transaction that ends in failure (not per retry). Codes 8'h0F do not count.
  - Start with dataa[8]=1 performs no UART traffic.
  - done pulses 2 cycles after enable, result=8'h00, rdata = zero-extended counter of the index.
  - Counters clear only on reset.
- Without the macro: dataa[8] is ignored and there is no counter logic.

Test Plan:
- Good frame: index=2; respond 8'h02, 8'h5A, checksum 8'h02^8'h5A^8'h37=8'h6F -> SendUart=8'h02, done once, result=8'h00, rdata=8'h5A.
- Bad checksum on every attempt: respond 8'h01, 8'h10, 8'h00 -> 3 requests sent (MAX_RETRY=2), result=8'h0E, rdata=0.
- Timeout: TIMEOUT_CYC=20, no response -> 3 requests ~20 cycles apart, result=8'h0C. Separately, an rx_valid on the expiry cycle is accepted with no timeout.
- Bad index 5 with N_SENSORS=4 -> tx_valid never asserted, done 2 cycles after enable, result=8'h0F.
- Reset mid-RECV_DATA, then a clean poll -> all outputs 0 after the reset edge; the next poll completes with 8'h00. Also: enable while busy is ignored, tx_ready held low stalls SEND indefinitely.
- SENSOR_STATS_EN: two failed polls of sensor 1, then a stats read of 1 -> rdata=8'h02, result=8'h00.
